fan_speed: RTL and testbench

- 8-bit PWM generator that drives a fan motor from a digital speed setpoint.
- A free-running counter defines a fixed 256-clock period; `pwm_data` is high for `speed` clocks of each period.
- The setpoint is sampled once per period, at period start, so a mid-period change never produces a glitch or a truncated pulse.
- Sits between the smart-home controller's fan-speed register and the fan driver pin.

---
 rtl/fan_speed.sv | 55 +++++
 tb/tb_fan_speed.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fan_speed.sv
// fan_speed: fixed-period PWM generator for a fan driver pin.
// A free-running WIDTH-bit counter sets a 2^WIDTH clock period. pwm_data is
// high for `speed` clocks of each period. The setpoint is only taken at
// period start, so mid-period changes never truncate or split a pulse.
// Optional build macro FAN_SPEED_PERIOD_PULSE_EN adds a period_start strobe
// aligned with the first pwm_data cycle of each period.
module fan_speed #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] speed,
`ifdef FAN_SPEED_PERIOD_PULSE_EN
    output logic             period_start,
`endif
    output logic             pwm_data
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] spd_q;
    logic [WIDTH-1:0] eff;
    logic             at_start;

    // The compare uses the live setpoint on the period's first edge, so the
    // new value takes effect with no extra cycle of latency.
    always_comb begin
        at_start = (cnt == '0);
        eff      = at_start ? speed : spd_q;
    end

    // Period counter, setpoint latch and registered PWM output.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt      <= '0;
            spd_q    <= '0;
            pwm_data <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;          // natural wrap, no idle cycle
            if (at_start)
                spd_q <= speed;
            pwm_data <= (cnt < eff);         // max setpoint leaves one low clock
        end
    end

`ifdef FAN_SPEED_PERIOD_PULSE_EN
    // One-clock strobe covering the first output cycle of every period.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            period_start <= 1'b0;
        else
            period_start <= at_start;
    end
`endif

endmodule

// File: tb/tb_fan_speed.sv
// Directed bench for fan_speed: reset, nominal duty, boundaries,
// mid-period setpoint change and mid-period reset.
module tb_fan_speed;

    logic       clk;
    logic       clk_en;
    logic       arst;
    logic [7:0] speed;
    logic       pwm_data;
`ifdef FAN_SPEED_PERIOD_PULSE_EN
    logic       period_start;
`endif

    int total = 0;
    int bad   = 0;

    fan_speed #(.WIDTH(8)) dut (
        .clk          (clk),
        .arst         (arst),
        .speed        (speed),
`ifdef FAN_SPEED_PERIOD_PULSE_EN
        .period_start (period_start),
`endif
        .pwm_data     (pwm_data)
    );

    // 80 ns clock, gated so reset can be checked with the clock stopped
    initial begin
        clk = 1'b0;
        forever #40 if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run edges first..last (edge 1 = first edge after reset release),
    // checking pwm_data against the setpoint in force for each edge.
    task automatic run_edges(input int first, input int last, input int spd,
                             input string tag, inout int highs);
        for (int e = first; e <= last; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_e%0d", tag, e), pwm_data, ((e - 1) % 256) < spd);
`ifdef FAN_SPEED_PERIOD_PULSE_EN
            chk($sformatf("%s_ps_e%0d", tag, e), period_start, ((e - 1) % 256) == 0);
`endif
            if (pwm_data === 1'b1) highs++;
        end
    endtask

    // Async reset with the clock running; release on a falling edge so the
    // next rising edge is edge 1.
    task automatic do_reset(input logic [7:0] spd, input string tag);
        arst = 1'b1;
        #7;
        chk({tag, "_rst_async"}, pwm_data, 1'b0);
        speed = spd;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_rst_held"}, pwm_data, 1'b0);
        arst = 1'b0;
    endtask

    initial begin
        int h;
        clk_en = 1'b0;
        arst   = 1'b0;
        speed  = 8'd0;

        // reset with the clock stopped
        #5 arst = 1'b1;
        #5;
        chk("rst_noclk", pwm_data, 1'b0);
        clk_en = 1'b1;
        @(negedge clk);
        arst = 1'b0;

        // speed=0 for 600 edges: never high
        h = 0;
        run_edges(1, 600, 0, "zero", h);
        chk_int("zero_highs", h, 0);

        // nominal 137, two periods
        do_reset(8'd137, "nom");
        h = 0;
        run_edges(1, 256, 137, "nom_p1", h);
        chk_int("nom_p1_highs", h, 137);
        h = 0;
        run_edges(257, 512, 137, "nom_p2", h);
        chk_int("nom_p2_highs", h, 137);

        // full-scale: one low clock per period
        do_reset(8'd255, "full");
        h = 0;
        run_edges(1, 256, 255, "full", h);
        chk_int("full_highs", h, 255);

        // minimum: single high clock per period
        do_reset(8'd1, "one");
        h = 0;
        run_edges(1, 512, 1, "one", h);
        chk_int("one_highs", h, 2);

        // mid-period change: current period stays 137, next is 50
        do_reset(8'd137, "mid");
        h = 0;
        run_edges(1, 99, 137, "mid_a", h);
        speed = 8'd50;
        run_edges(100, 256, 137, "mid_b", h);
        chk_int("mid_p1_highs", h, 137);
        h = 0;
        run_edges(257, 512, 50, "mid_c", h);
        chk_int("mid_p2_highs", h, 50);

        // reset at edge 70 while high; pattern restarts from edge 1
        do_reset(8'd137, "rmid");
        h = 0;
        run_edges(1, 70, 137, "rmid_pre", h);
        chk("rmid_high_before", pwm_data, 1'b1);
        do_reset(8'd137, "rmid2");
        h = 0;
        run_edges(1, 256, 137, "rmid_post", h);
        chk_int("rmid_post_highs", h, 137);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
